// File: rtl/opb_register_simulink2ppc_snap.sv
// opb_register_simulink2ppc_snap
//
// Fabric-to-processor snapshot register on the OPB bus. User logic strobes a
// 32-bit word in with user_data_valid; the block keeps the captured word plus
// a status word (fresh, sticky overrun, 16-bit update count). The processor
// reads both through a single-cycle-ack OPB slave. Everything runs on OPB_Clk.
//
// Register map (byte offsets from C_BASEADDR):
//   0x0 DATA   RO  captured word; a read-ack clears fresh
//   0x4 STATUS RW  [0] fresh, [1] overrun (W1C), [2] count clear (W1, reads 0),
//                  [31:16] update count; writes need OPB_BE[3]
//   >=0x8      reads 0, writes acked and ignored
//
// Ports:
//   OPB_Clk, OPB_Rst_n           clock, asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW/select  OPB master request (big-endian bit numbering)
//   OPB_seqAddr                  ignored
//   Sl_DBus, Sl_xferAck          registered read data / acknowledge
//   Sl_errAck, Sl_retry, Sl_toutSup  tied low
//   user_data_in, user_data_valid    fabric capture port
//
// Build option: define SNAP_HOLD_EN to drop captures that would overwrite an
// unread word (hold-first); otherwise the latest word wins.

module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter logic [63:0] C_FAMILY     = "virtex5"
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    input  logic [31:0] user_data_in,
    input  logic        user_data_valid
);

    typedef enum logic {StIdle, StAck} state_e;

    state_e      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        fresh_q, fresh_d;
    logic        ovr_q, ovr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    // Side effects of the accepted transfer, applied at the edge ending its ack.
    logic        rd_data_q, clr_ovr_q, clr_cnt_q;

    logic        hit, accept, in_regs, sel_status;
    logic [31:0] offset;
    logic        data_read_ack, clr_ovr, clr_cnt;
    logic        conflict, take;

    assign hit        = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign accept     = (state_q == StIdle) && hit;
    assign offset     = OPB_ABus - C_BASEADDR;
    assign in_regs    = (offset[31:3] == 29'd0);
    assign sel_status = OPB_ABus[29];

    assign data_read_ack = (state_q == StAck) && rd_data_q;
    assign clr_ovr       = (state_q == StAck) && clr_ovr_q;
    assign clr_cnt       = (state_q == StAck) && clr_cnt_q;

    // A same-cycle DATA read-ack consumes the old word, so it is not an overrun.
    assign conflict = user_data_valid && fresh_q && !data_read_ack;
`ifdef SNAP_HOLD_EN
    assign take = user_data_valid && !conflict;
`else
    assign take = user_data_valid;
`endif

    always_comb begin
        data_d  = take ? user_data_in : data_q;
        fresh_d = fresh_q;
        if (take) begin
            fresh_d = 1'b1;
        end else if (data_read_ack) begin
            fresh_d = 1'b0;
        end
        // Set beats a concurrent clear.
        ovr_d = conflict || (ovr_q && !clr_ovr);
        cnt_d = (clr_cnt ? 16'd0 : cnt_q) + {15'd0, take};
    end

    // Read data is taken from next-state values so a capture in the cycle the
    // hit is sampled is already visible in the following ack cycle. Accepts
    // only happen in IDLE, where no write side effect is pending.
    always_comb begin
        rdata_d = 32'd0;
        if (accept && OPB_RNW && in_regs) begin
            rdata_d = sel_status ? {cnt_d, 14'd0, ovr_d, fresh_d} : data_d;
        end
    end

    // Slave FSM: state register
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Slave FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (hit) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Slave FSM: outputs (decoded from registers only)
    always_comb begin
        Sl_xferAck = (state_q == StAck);
        Sl_DBus    = rdata_q;
        Sl_errAck  = 1'b0;
        Sl_retry   = 1'b0;
        Sl_toutSup = 1'b0;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            data_q    <= 32'd0;
            fresh_q   <= 1'b0;
            ovr_q     <= 1'b0;
            cnt_q     <= 16'd0;
            rdata_q   <= 32'd0;
            rd_data_q <= 1'b0;
            clr_ovr_q <= 1'b0;
            clr_cnt_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            fresh_q   <= fresh_d;
            ovr_q     <= ovr_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rd_data_q <= accept && OPB_RNW && in_regs && !sel_status;
            clr_ovr_q <= accept && !OPB_RNW && in_regs && sel_status && OPB_BE[3] && OPB_DBus[30];
            clr_cnt_q <= accept && !OPB_RNW && in_regs && sel_status && OPB_BE[3] && OPB_DBus[29];
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{OPB_seqAddr, OPB_BE, OPB_DBus, offset[2:0],
                             C_FAMILY, C_OPB_AWIDTH, C_OPB_DWIDTH};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] Base = 32'h8000_0000;
    localparam logic [31:0] High = 32'h8000_00FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:31] opb_abus = '0;
    logic [0:3]  opb_be = '0;
    logic [0:31] opb_dbus = '0;
    logic        opb_rnw = 1'b0;
    logic        opb_select = 1'b0;
    logic        opb_seqaddr = 1'b0;
    logic [0:31] sl_dbus;
    logic        sl_xferack, sl_erracK_unused, sl_retry, sl_toutsup;
    logic [31:0] user_data = '0;
    logic        user_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    // Behavioural model of the register state
    logic [31:0] m_data;
    logic        m_fresh, m_ovr;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    opb_register_simulink2ppc_snap #(
        .C_BASEADDR(Base),
        .C_HIGHADDR(High)
    ) dut (
        .OPB_Clk        (clk),
        .OPB_Rst_n      (rst_n),
        .OPB_ABus       (opb_abus),
        .OPB_BE         (opb_be),
        .OPB_DBus       (opb_dbus),
        .OPB_RNW        (opb_rnw),
        .OPB_select     (opb_select),
        .OPB_seqAddr    (opb_seqaddr),
        .Sl_DBus        (sl_dbus),
        .Sl_xferAck     (sl_xferack),
        .Sl_errAck      (sl_erracK_unused),
        .Sl_retry       (sl_retry),
        .Sl_toutSup     (sl_toutsup),
        .user_data_in   (user_data),
        .user_data_valid(user_valid)
    );

    function automatic logic [31:0] m_status();
        return {m_cnt, 14'd0, m_ovr, m_fresh};
    endfunction

    task automatic m_reset();
        m_data = '0; m_fresh = 0; m_ovr = 0; m_cnt = '0;
    endtask

    // One fabric word arriving; read_ack means a DATA read was acked that cycle.
    task automatic m_capture(input logic [31:0] d, input bit read_ack);
        bit busy;
        busy = m_fresh && !read_ack;
        if (busy) m_ovr = 1;
`ifdef SNAP_HOLD_EN
        if (busy) return;
`endif
        m_data = d;
        m_fresh = 1;
        m_cnt = m_cnt + 16'd1;
    endtask

    // Transaction-level effect of one bus access; returns the expected read data.
    task automatic m_xfer(input logic [31:0] addr, input bit rnw, input logic [3:0] be,
                          input logic [31:0] wdata, output logic [31:0] exp_rd,
                          output bit was_data_read);
        logic [31:0] off;
        off = addr - Base;
        exp_rd = '0;
        was_data_read = 0;
        if (off < 8) begin
            if (rnw) begin
                if (off[2]) exp_rd = m_status();
                else begin
                    exp_rd = m_data;
                    m_fresh = 0;
                    was_data_read = 1;
                end
            end else if (off[2] && be[0]) begin
                if (wdata[1]) m_ovr = 0;
                if (wdata[2]) m_cnt = '0;
            end
        end
    endtask

    // Drives one OPB access starting #1 after an edge; optionally pulses
    // user_data_valid during the ack cycle. Ends #1 after the edge closing the ack.
    task automatic xfer(input logic [31:0] addr, input bit rnw, input logic [3:0] be,
                        input logic [31:0] wdata, input bit v_in_ack, input logic [31:0] vdata,
                        output logic [31:0] rdata, output bit acked, output int lat);
        opb_abus = addr;
        opb_rnw = rnw;
        opb_be = be;
        opb_dbus = rnw ? 32'd0 : wdata;
        opb_select = 1'b1;
        acked = 0;
        rdata = '0;
        lat = 0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk); #1;
            lat++;
            if (sl_xferack) begin
                acked = 1;
                rdata = sl_dbus;
            end
        end
        opb_select = 1'b0;
        if (acked && v_in_ack) begin
            user_valid = 1'b1;
            user_data = vdata;
        end
        @(posedge clk); #1;
        user_valid = 1'b0;
    endtask

    // Model-checked access; name labels any FAIL line.
    task automatic bus_op(input string name, input logic [31:0] addr, input bit rnw,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input bit v_in_ack, input logic [31:0] vdata);
        logic [31:0] rd, exp;
        bit acked, dr;
        int lat;
        xfer(addr, rnw, be, wdata, v_in_ack, vdata, rd, acked, lat);
        m_xfer(addr, rnw, be, wdata, exp, dr);
        if (v_in_ack && acked) m_capture(vdata, dr);
        checks++;
        if (!acked || lat != 1) begin
            failures++;
            $display("FAIL %s ack: acked=%0d latency=%0d required acked=1 latency=1", name, acked, lat);
        end
        if (rnw) begin
            checks++;
            if (rd !== exp) begin
                failures++;
                $display("FAIL %s rdata: got %08h required %08h", name, rd, exp);
            end
        end
    endtask

    task automatic pulse_valid(input logic [31:0] d);
        user_valid = 1'b1;
        user_data = d;
        @(posedge clk); #1;
        user_valid = 1'b0;
        m_capture(d, 0);
    endtask

    task automatic test_reset();
        checks++;
        if (sl_xferack !== 1'b0 || sl_dbus !== 32'd0) begin
            failures++;
            $display("FAIL reset outputs: ack=%b dbus=%08h required 0/00000000", sl_xferack, sl_dbus);
        end
        checks++;
        if ({sl_erracK_unused, sl_retry, sl_toutsup} !== 3'b000) begin
            failures++;
            $display("FAIL tieoffs: got %b required 000", {sl_erracK_unused, sl_retry, sl_toutsup});
        end
        bus_op("reset_data", Base, 1, 4'hF, 0, 0, 0);
        bus_op("reset_status", Base + 4, 1, 4'hF, 0, 0, 0);
    endtask

    task automatic test_capture();
        logic [31:0] rd;
        bit acked, dr;
        int lat;
        logic [31:0] exp;
        pulse_valid(32'hDEAD_BEEF);
        bus_op("cap_status1", Base + 4, 1, 4'hF, 0, 0, 0);
        xfer(Base, 1, 4'hF, 0, 0, 0, rd, acked, lat);
        m_xfer(Base, 1, 4'hF, 0, exp, dr);
        checks++;
        if (!acked || rd !== exp || rd[31:24] !== 8'hDE) begin
            failures++;
            $display("FAIL cap_data: got %08h acked=%0d required %08h top byte DE", rd, acked, exp);
        end
        bus_op("cap_status2", Base + 4, 1, 4'hF, 0, 0, 0);
    endtask

    task automatic test_overrun();
        bus_op("ovr_clear", Base + 4, 0, 4'hF, 32'h6, 0, 0);
        pulse_valid(32'h1);
        pulse_valid(32'h2);
        bus_op("ovr_status", Base + 4, 1, 4'hF, 0, 0, 0);
        bus_op("ovr_data", Base, 1, 4'hF, 0, 0, 0);
    endtask

    task automatic test_status_write();
        pulse_valid($urandom);
        pulse_valid($urandom);
        bus_op("wr_be_miss", Base + 4, 0, 4'b1110, 32'h6, 0, 0);
        bus_op("wr_be_miss_chk", Base + 4, 1, 4'hF, 0, 0, 0);
        bus_op("wr_be_hit", Base + 4, 0, 4'b0001, 32'h6, 0, 0);
        bus_op("wr_be_hit_chk", Base + 4, 1, 4'hF, 0, 0, 0);
        bus_op("wr_data_ignored", Base, 0, 4'hF, 32'h1234_5678, 0, 0);
        bus_op("wr_data_chk", Base, 1, 4'hF, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        pulse_valid(32'hAAAA_0001);
        bus_op("sim_read_old", Base, 1, 4'hF, 0, 1, 32'hBBBB_0002);
        bus_op("sim_status", Base + 4, 1, 4'hF, 0, 0, 0);
        // Overrun clear against overrun set, count clear against capture.
        bus_op("sim_clr", Base + 4, 0, 4'hF, 32'h6, 1, 32'hCCCC_0003);
        bus_op("sim_clr_chk", Base + 4, 1, 4'hF, 0, 0, 0);
        bus_op("sim_clr_data", Base, 1, 4'hF, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        logic [31:0] exp;
        bit dr;
        opb_abus = Base + 4;
        opb_rnw = 1'b1;
        opb_be = 4'hF;
        opb_select = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            got[3 - i] = sl_xferack;
            if (sl_xferack) begin
                m_xfer(Base + 4, 1, 4'hF, 0, exp, dr);
                checks++;
                if (sl_dbus !== exp) begin
                    failures++;
                    $display("FAIL b2b rdata: got %08h required %08h", sl_dbus, exp);
                end
            end
        end
        opb_select = 1'b0;
        checks++;
        if (got !== 4'b1010) begin
            failures++;
            $display("FAIL b2b ack pattern: got %b required 1010", got);
        end
        @(posedge clk); #1;
        checks++;
        if (sl_xferack !== 1'b0 || sl_dbus !== 32'd0) begin
            failures++;
            $display("FAIL b2b idle: ack=%b dbus=%08h required 0/00000000", sl_xferack, sl_dbus);
        end
    endtask

    task automatic test_offsets();
        logic [31:0] rd;
        bit acked;
        int lat;
        bus_op("off_0x10", Base + 32'h10, 1, 4'hF, 0, 0, 0);
        bus_op("off_0x08", Base + 32'h8, 1, 4'hF, 0, 0, 0);
        bus_op("off_wr_0x0c", Base + 32'hC, 0, 4'hF, 32'h6, 0, 0);
        bus_op("off_chk", Base + 4, 1, 4'hF, 0, 0, 0);
        xfer(High + 1, 1, 4'hF, 0, 0, 0, rd, acked, lat);
        checks++;
        if (acked) begin
            failures++;
            $display("FAIL miss: acked=1 rdata=%08h required no ack", rd);
        end
    endtask

    task automatic test_wrap();
        bus_op("wrap_clear", Base + 4, 0, 4'hF, 32'h6, 0, 0);
        user_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            user_data = $urandom;
            @(posedge clk); #1;
            m_capture(user_data, 0);
        end
        user_valid = 1'b0;
        bus_op("wrap_status", Base + 4, 1, 4'hF, 0, 0, 0);
`ifndef SNAP_HOLD_EN
        checks++;
        if (m_cnt !== 16'd0) begin
            failures++;
            $display("FAIL wrap model: count %04h required 0000", m_cnt);
        end
`endif
        bus_op("wrap_data", Base, 1, 4'hF, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 6);
            case (op)
                0, 1: pulse_valid($urandom);
                2: bus_op("rnd_data", Base, 1, 4'hF, 0, $urandom_range(0, 1), $urandom);
                3: bus_op("rnd_status", Base + 4, 1, 4'hF, 0, $urandom_range(0, 1), $urandom);
                4: bus_op("rnd_write", Base + 4, 0, 4'($urandom), $urandom & 32'h7,
                          $urandom_range(0, 1), $urandom);
                5: bus_op("rnd_high", Base + (32'($urandom_range(2, 63)) << 2), 1, 4'hF, 0, 0, 0);
                default: begin
                    @(posedge clk); #1;
                end
            endcase
        end
    endtask

    task automatic test_reset_mid();
        pulse_valid(32'h5555_AAAA);
        opb_abus = Base;
        opb_rnw = 1'b1;
        opb_be = 4'hF;
        opb_select = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sl_xferack !== 1'b1) begin
            failures++;
            $display("FAIL rstmid pre-ack: ack=%b required 1", sl_xferack);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sl_xferack !== 1'b0 || sl_dbus !== 32'd0) begin
            failures++;
            $display("FAIL rstmid drop: ack=%b dbus=%08h required 0/00000000", sl_xferack, sl_dbus);
        end
        opb_select = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_reset();
        @(posedge clk); #1;
        bus_op("rstmid_status", Base + 4, 1, 4'hF, 0, 0, 0);
        bus_op("rstmid_data", Base, 1, 4'hF, 0, 0, 0);
    endtask

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_capture();
        test_overrun();
        test_status_write();
        test_simultaneous();
        test_back_to_back();
        test_offsets();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
